// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------------------------
// seg7_scan_decoder
//
// Watches a time-multiplexed, active-low 7-segment bus and turns it back into hex digits.
// seg_n and dig_en are each synchronised, then every digit slot is debounced. A pattern that
// holds for STABLE_CYC consecutive samples is decoded once per slot. When the strobe leaves the
// last digit and every digit of the scan decoded cleanly, the scan is committed as one frame
// on a valid/ready output.
//
// Parameters
//   NDIG        number of multiplexed digits (>= 1)
//   STABLE_CYC  identical consecutive samples needed to capture a digit (>= 1)
//
// Ports
//   clock        single clock for the whole block
//   reset        asynchronous, active-high reset
//   seg_n        active-low segments, bit0 = a ... bit6 = g
//   dig_en       active-high digit strobe, expected one-hot
//   frame_data   committed frame, digit i on [4i+3:4i]
//   frame_valid  frame_data holds an unconsumed frame
//   frame_ready  consumer takes the frame when frame_valid & frame_ready
//   seg_err      one-cycle pulse: a stable pattern was not a legal digit
//   overrun      one-cycle pulse: a pending frame was overwritten
//   blank_mask   per-digit blank flags of the frame on frame_data
//
// Build option
//   SEG7_BLANK_EN  when defined, the all-off pattern 7F is a legal blank digit (nibble 0, blank
//                  flag set). When undefined, 7F is illegal and blank_mask is tied to 0.
// ---------------------------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned STABLE_CYC = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [6:0]        seg_n,
  input  logic [NDIG-1:0]   dig_en,
  output logic [4*NDIG-1:0] frame_data,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              seg_err,
  output logic              overrun,
  output logic [NDIG-1:0]   blank_mask
);

  localparam int unsigned CntW = $clog2(STABLE_CYC + 1);
  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYC);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIG - 1);
  localparam logic [6:0]      SegOff  = 7'h7F;

  // Returns {legal, nibble}. The all-off pattern is handled separately when blanking is enabled.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] res;
    res = 5'b0_0000;
    case (pat)
      7'h40:   res = 5'b1_0000;
      7'h79:   res = 5'b1_0001;
      7'h24:   res = 5'b1_0010;
      7'h30:   res = 5'b1_0011;
      7'h19:   res = 5'b1_0100;
      7'h12:   res = 5'b1_0101;
      7'h02:   res = 5'b1_0110;
      7'h78:   res = 5'b1_0111;
      7'h00:   res = 5'b1_1000;
      7'h10:   res = 5'b1_1001;
      7'h08:   res = 5'b1_1010;
      7'h03:   res = 5'b1_1011;
      7'h46:   res = 5'b1_1100;
      7'h21:   res = 5'b1_1101;
      7'h06:   res = 5'b1_1110;
      7'h0E:   res = 5'b1_1111;
`ifdef SEG7_BLANK_EN
      7'h7F:   res = 5'b1_0000;
`endif
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  // -------------------------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------------------------
  logic [6:0]        seg_meta_q, seg_sync_q;
  logic [NDIG-1:0]   dig_meta_q, dig_sync_q;

  // Previous-cycle view of the synchronised bus, used to detect digit/pattern changes.
  logic              prev_valid_q, prev_valid_d;
  logic [IdxW-1:0]   prev_idx_q, prev_idx_d;
  logic [6:0]        prev_seg_q, prev_seg_d;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [NDIG-1:0]   got_q, got_d;
  logic [4*NDIG-1:0] cap_q, cap_d;

  logic [4*NDIG-1:0] frame_data_q, frame_data_d;
  logic              frame_valid_q, frame_valid_d;
  logic              seg_err_q, seg_err_d;
  logic              overrun_q, overrun_d;

`ifdef SEG7_BLANK_EN
  logic [NDIG-1:0]   blank_cap_q, blank_cap_d;
  logic [NDIG-1:0]   blank_mask_q, blank_mask_d;
  logic              dec_blank;
`endif

  // -------------------------------------------------------------------------------------------
  // Combinational decode
  // -------------------------------------------------------------------------------------------
  logic            act_hit, act_multi, act_valid;
  logic [IdxW-1:0] act_idx;
  logic            dig_change, pat_change;
  logic            capture, frame_end, commit;
  logic [4:0]      dec;
  logic            dec_legal;
  logic [3:0]      dec_nib;

  // Active digit: exactly one strobe bit set; zero or several bits set means "none".
  always_comb begin
    act_hit   = 1'b0;
    act_multi = 1'b0;
    act_idx   = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (dig_sync_q[i]) begin
        if (act_hit) begin
          act_multi = 1'b1;
        end
        act_hit = 1'b1;
        act_idx = IdxW'(i);
      end
    end
    act_valid = act_hit & ~act_multi;
  end

  always_comb begin
    dec       = seg_decode(seg_sync_q);
    dec_legal = dec[4];
    dec_nib   = dec[3:0];
`ifdef SEG7_BLANK_EN
    dec_blank = (seg_sync_q == SegOff);
`endif
  end

  always_comb begin
    dig_change = (act_valid != prev_valid_q) |
                 (act_valid & prev_valid_q & (act_idx != prev_idx_q));
    pat_change = (seg_sync_q != prev_seg_q);

    // Stability counter: cleared while no digit is active, restarted on any change.
    if (!act_valid) begin
      cnt_d = '0;
    end else if (dig_change || pat_change) begin
      cnt_d = CntOne;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntOne;
    end else begin
      cnt_d = cnt_q;
    end

    // done_q blocks a second capture in the same slot, even if the pattern changes and settles
    // again; only a change of active digit re-arms it.
    capture = act_valid & (cnt_d == CntMax) & ~(done_q & ~dig_change);
    if (capture) begin
      done_d = 1'b1;
    end else if (dig_change) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end

    frame_end = prev_valid_q & (prev_idx_q == LastIdx) & ~(act_valid & (act_idx == LastIdx));
    commit    = frame_end & (&got_q);

    prev_valid_d = act_valid;
    prev_idx_d   = act_idx;
    prev_seg_d   = seg_sync_q;
  end

  // Capture bookkeeping. The frame-end clear happens first so a capture in the same cycle
  // belongs to the next frame.
  always_comb begin
    cap_d = cap_q;
    got_d = frame_end ? '0 : got_q;
`ifdef SEG7_BLANK_EN
    blank_cap_d = blank_cap_q;
`endif
    if (capture) begin
      for (int i = 0; i < int'(NDIG); i++) begin
        if (act_idx == IdxW'(i)) begin
          got_d[i] = dec_legal;
          if (dec_legal) begin
            cap_d[4*i +: 4] = dec_nib;
`ifdef SEG7_BLANK_EN
            blank_cap_d[i] = dec_blank;
`endif
          end
        end
      end
    end
  end

  // Output frame register and handshake.
  always_comb begin
    frame_data_d  = commit ? cap_q : frame_data_q;
    frame_valid_d = commit | (frame_valid_q & ~frame_ready);
    overrun_d     = commit & frame_valid_q & ~frame_ready;
    seg_err_d     = capture & ~dec_legal;
`ifdef SEG7_BLANK_EN
    blank_mask_d  = commit ? blank_cap_q : blank_mask_q;
`endif
  end

  // -------------------------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_meta_q    <= SegOff;
      seg_sync_q    <= SegOff;
      dig_meta_q    <= '0;
      dig_sync_q    <= '0;
      prev_valid_q  <= 1'b0;
      prev_idx_q    <= '0;
      prev_seg_q    <= SegOff;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      got_q         <= '0;
      cap_q         <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      seg_meta_q    <= seg_n;
      seg_sync_q    <= seg_meta_q;
      dig_meta_q    <= dig_en;
      dig_sync_q    <= dig_meta_q;
      prev_valid_q  <= prev_valid_d;
      prev_idx_q    <= prev_idx_d;
      prev_seg_q    <= prev_seg_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      got_q         <= got_d;
      cap_q         <= cap_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      overrun_q     <= overrun_d;
    end
  end

`ifdef SEG7_BLANK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blank_cap_q  <= '0;
      blank_mask_q <= '0;
    end else begin
      blank_cap_q  <= blank_cap_d;
      blank_mask_q <= blank_mask_d;
    end
  end

  assign blank_mask = blank_mask_q;
`else
  assign blank_mask = '0;
`endif

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign seg_err     = seg_err_q;
  assign overrun     = overrun_q;

endmodule
